// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
package fetch_pkg;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;
    localparam int RESET_PC  = 0;
    localparam int BUF_DEPTH = 2;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} between imem and decode; registered head.
// Push and pop may coincide; flush empties it but leaves stale storage in place.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int AW = fetch_pkg::ADDR_W,
    parameter int DW = fetch_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic [DW-1:0] push_instr_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          valid_o,
    output logic [AW-1:0] head_pc_o,
    output logic [DW-1:0] head_instr_o,
    output logic [1:0]    count_o
);
    logic [AW-1:0] pc_q    [BUF_DEPTH];
    logic [DW-1:0] instr_q [BUF_DEPTH];
    logic          rd_q;
    logic          wr_q;
    logic [1:0]    count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                pc_q[wr_q]    <= push_pc_i;
                instr_q[wr_q] <= push_instr_i;
                wr_q          <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign valid_o      = (count_q != 2'd0);
    assign head_pc_o    = pc_q[rd_q];
    assign head_instr_o = instr_q[rd_q];
    assign count_o      = count_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, tracks the one-cycle imem read and buffers words for decode.
// Issue-to-out_valid is 2 cycles; at most 2 words are ever buffered or in flight.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = fetch_pkg::ADDR_W,
    parameter int DATA_W   = fetch_pkg::DATA_W,
    parameter int RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);
    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              push;
    logic              issue;

    assign imem_addr = redirect_valid ? redirect_pc : pc_q;
    assign pop       = out_valid && out_ready;

    // Credit check: a freed slot this cycle lets a new fetch issue immediately.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == S_RUN) && !halt && (occupancy < 3'd2);

    // A redirect makes the word returning this cycle stale.
    assign push = inflight_q && !redirect_valid;
    assign pc_d = issue ? ADDR_W'(imem_addr + 1'b1) : imem_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            case (state_q)
                S_RUN:   if (halt)  state_q <= S_HALT;
                S_HALT:  if (!halt) state_q <= S_RUN;
                default: state_q <= S_RUN;
            endcase
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= imem_addr;
            end
        end
    end

    fetch_buf #(
        .AW(ADDR_W),
        .DW(DATA_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_pc_i   (inflight_pc_q),
        .push_instr_i(imem_instr),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .valid_o     (out_valid),
        .head_pc_o   (out_pc),
        .head_instr_o(out_instr),
        .count_o     (count)
    );
endmodule
